// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor (diff = a - b - bin).
// One full-subtractor stage is reused every clock, LSB first, with the
// borrow carried in a register between bits.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   diff, bout           a - b - bin modulo 2^WIDTH, final borrow-out
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic             brw, brw_nx, d_bit;
    logic             x, y;
    logic [CW-1:0]    cnt;
    logic             accept, last, consume;

    // ------------------------------------------------------------------
    // Handshake qualifiers and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        accept   = (state == IDLE) && in_valid && in_ready;
        last     = (state == CALC) && (cnt == LAST);
        consume  = (state == DONE) && out_ready;
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = CALC;
            CALC:    if (last)    state_nx = DONE;
            DONE:    if (consume) state_nx = IDLE;
            default:              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Single full-subtractor stage on the current LSBs
    // ------------------------------------------------------------------
    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        d_bit  = x ^ y ^ brw;
        brw_nx = (~x & y) | (~(x ^ y) & brw);
        // Result fills from the top so that after WIDTH shifts bit 0 holds
        // the first (LSB) difference bit. Written this way to stay legal
        // for WIDTH = 1.
        res_nx            = res >> 1;
        res_nx[WIDTH-1]   = d_bit;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            // in_ready is registered so it first rises on the edge after
            // reset release, and again on the edge a result is consumed.
            in_ready <= (state_nx == IDLE);

            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                res  <= '0;
                cnt  <= '0;
            end else if (state == CALC) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                brw  <= brw_nx;
                res  <= res_nx;
                if (last) begin
                    diff      <= res_nx;
                    bout      <= brw_nx;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // WIDTH = 8 instance
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, bout8;

    // WIDTH = 1 instance
    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       bin1 = 1'b0, bout1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q8[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands.
    function automatic exp_t model(input int w, input longint av, input longint bv,
                                   input longint bi, input int acc);
        exp_t e;
        longint full;
        full  = av - bv - bi;
        e.d   = 32'(full & ((longint'(1) << w) - 1));
        e.bo  = (av < bv + bi);
        e.acc = acc;
        return e;
    endfunction

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input bit keep, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1;
        while (!in_ready8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            chk("accept8_timeout", 0, 1);
            acc = -1;
        end else begin
            acc = cyc;
            q8.push_back(model(8, longint'(av), longint'(bv), longint'(bi), acc));
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid8 = 1'b0;
    endtask

    task automatic send1(input logic av, input logic bv, input logic bi);
        int n;
        n = 0;
        @(negedge clk);
        a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1;
        while (!in_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) chk("accept1_timeout", 0, 1);
        else q1.push_back(model(1, longint'(av), longint'(bv), longint'(bi), cyc));
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q8", q8.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Monitors: pop and compare on every completed result handshake
    // ------------------------------------------------------------------
    logic       pv8 = 0, pr8 = 0, pb8 = 0;
    logic [7:0] pd8 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv8 = 0;
        end else begin
            if (out_valid8 && !pv8 && q8.size() != 0)
                chk("latency8", cyc - q8[0].acc, 9);
            if (pv8 && pr8)
                chk("valid8_drops_after_hs", out_valid8, 0);
            if (pv8 && !pr8) begin
                chk("valid8_held_in_stall", out_valid8, 1);
                chk("diff8_stable", diff8, pd8);
                chk("bout8_stable", bout8, pb8);
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_result8", 1, 0);
                end else begin
                    chk("diff8", diff8, q8[0].d);
                    chk("bout8", bout8, q8[0].bo);
                    void'(q8.pop_front());
                end
            end
            pv8 = out_valid8; pr8 = out_ready8; pd8 = diff8; pb8 = bout8;
        end
    end

    logic pv1 = 0, pr1 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv1 = 0;
        end else begin
            if (out_valid1 && !pv1 && q1.size() != 0)
                chk("latency1", cyc - q1[0].acc, 2);
            if (pv1 && pr1)
                chk("valid1_drops_after_hs", out_valid1, 0);
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_result1", 1, 0);
                end else begin
                    chk("diff1", diff1, q1[0].d);
                    chk("bout1", bout1, q1[0].bo);
                    void'(q1.pop_front());
                end
            end
            pv1 = out_valid1; pr1 = out_ready1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc, prev, n;
        logic [7:0] cd;
        logic cb;

        repeat (3) @(negedge clk);
        chk("rst_ov8", out_valid8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_ov1", out_valid1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready8_after_rst", in_ready8, 1);

        // Directed cases
        send8(8'h05, 8'h03, 1'b0, 0, acc);
        send8(8'h03, 8'h05, 1'b0, 0, acc);
        send8(8'h00, 8'h00, 1'b1, 0, acc);
        send8(8'hFF, 8'hFF, 1'b1, 0, acc);
        drain(100);

        // Back-pressure with in_valid pulses that must be ignored
        @(posedge clk); #1; out_ready8 = 1'b0;
        send8(8'h3C, 8'h0F, 1'b0, 0, acc);
        n = 0;
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_rise", out_valid8, 1);
        cd = diff8; cb = bout8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = 8'h11; b8 = 8'h00; bin8 = 1'b0; in_valid8 = 1'b1;
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_diff", diff8, cd);
            chk("bp_bout", bout8, cb);
            @(posedge clk); #1;
            in_valid8 = 1'b0;
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_fall", out_valid8, 0);
        chk("bp_in_ready_back", in_ready8, 1);
        drain(50);

        // Reset in the middle of CALC
        send8(8'h80, 8'h01, 1'b0, 0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("midrst_ov", out_valid8, 0);
        chk("midrst_diff", diff8, 0);
        chk("midrst_bout", bout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_result", out_valid8, 0);
        send8(8'hA5, 8'h5A, 1'b0, 0, acc);
        drain(50);

        // Full-subtractor truth table on the WIDTH = 1 instance
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send1(v[2], v[1], v[0]);
        end
        drain(20);

        // Throughput: in_valid held high, out_ready tied high
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1, acc);
            if (prev >= 0) chk("spacing", acc - prev, 10);
            prev = acc;
        end
        in_valid8 = 1'b0;
        drain(50);

        // Randomized operands with random back-pressure
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            out_ready8 = 1'($urandom_range(0, 1));
            send8(8'($urandom), 8'($urandom), 1'($urandom), 0, acc);
            n = 0;
            while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
            if (!out_valid8) chk("rand_valid_timeout", 0, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(posedge clk); #1;
            out_ready8 = 1'b1;
            @(posedge clk); #1;
        end
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
